// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI3 responder backed by a word-organised on-chip RAM. It serves the INCR
//   read bursts (cache refills) and the write bursts (write-backs, uncached
//   stores) issued by the CPU kernel's AXI master ports. The read and write
//   channels run independent FSMs, with one outstanding transaction each.
//
// Parameters
//   ADDR_BITS : log2 of memory size in 32-bit words (12 -> 16 KiB)
//   READ_LAT  : idle cycles between the AR handshake and the first R beat (0..15)
//
// Ports
//   i_clk, i_resetn                  clock, asynchronous active-low reset
//   i_ar*/o_arready                  read address channel (lock/cache/prot ignored)
//   o_r*/i_rready                    read data channel
//   i_aw*/o_awready                  write address channel (lock/cache/prot ignored)
//   i_w*/o_wready                    write data channel (wid ignored)
//   o_b*/i_bready                    write response channel
// ---------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int ADDR_BITS = 12,
  parameter int READ_LAT  = 2
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  // read address
  input  logic [3:0]  i_arid,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  input  logic [1:0]  i_arlock,
  input  logic [3:0]  i_arcache,
  input  logic [2:0]  i_arprot,
  input  logic        i_arvalid,
  output logic        o_arready,
  // read data
  output logic [3:0]  o_rid,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rlast,
  output logic        o_rvalid,
  input  logic        i_rready,
  // write address
  input  logic [3:0]  i_awid,
  input  logic [31:0] i_awaddr,
  input  logic [7:0]  i_awlen,
  input  logic [2:0]  i_awsize,
  input  logic [1:0]  i_awburst,
  input  logic [1:0]  i_awlock,
  input  logic [3:0]  i_awcache,
  input  logic [2:0]  i_awprot,
  input  logic        i_awvalid,
  output logic        o_awready,
  // write data
  input  logic [3:0]  i_wid,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_wlast,
  input  logic        i_wvalid,
  output logic        o_wready,
  // write response
  output logic [3:0]  o_bid,
  output logic [1:0]  o_bresp,
  output logic        o_bvalid,
  input  logic        i_bready
);

  localparam int         WORDS       = 1 << ADDR_BITS;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rdState_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wrState_t;

  logic [31:0] r_mem [WORDS];

  // An address hits the RAM only when every bit above the word index is zero.
  function automatic logic inRange(input logic [31:0] a);
    return a[31:ADDR_BITS+2] == '0;
  endfunction

  function automatic logic [ADDR_BITS-1:0] wordIdx(input logic [31:0] a);
    return a[ADDR_BITS+1:2];
  endfunction

  // INCR steps one word; FIXED keeps hitting the same word.
  function automatic logic [31:0] nextAddr(input logic [31:0] a, input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + 32'd4 : a;
  endfunction

  // Sideband fields the memory has no use for.
  logic w_unused;
  assign w_unused = ^{i_arlock, i_arcache, i_arprot, i_awlock, i_awcache, i_awprot, i_wid};

  // ------------------------------------------------------------------ read
  rdState_t    r_rdState;
  logic        r_arready;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rlast;
  logic        r_rvalid;
  logic [31:0] r_rdAddr;
  logic [7:0]  r_rdRem;
  logic [1:0]  r_rdBurst;
  logic        r_rdLegal;
  logic [3:0]  r_rdCnt;

  logic        w_arHs;
  logic        w_rHs;
  logic        w_arLegal;
  logic [31:0] w_rdFetchAddr;
  logic        w_rdFetchLegal;
  logic        w_rdFetchErr;
  logic [31:0] w_rdFetchData;

  assign w_arHs    = i_arvalid && r_arready;
  assign w_rHs     = r_rvalid && i_rready;
  assign w_arLegal = (i_arsize == 3'b010) && (i_arburst == BURST_INCR || i_arburst == BURST_FIXED);

  // Selects the address of the beat about to be loaded into the R registers:
  // the incoming AR address when starting with no latency, the latched address
  // when leaving the wait state, or the next address after an accepted beat.
  // Sampling the RAM here at the clock edge means a same-cycle write to the
  // same word is seen only by later beats, and the payload stays put while
  // the master stalls.
  always_comb begin
    w_rdFetchAddr  = r_rdAddr;
    w_rdFetchLegal = r_rdLegal;
    case (r_rdState)
      R_IDLE: begin
        w_rdFetchAddr  = i_araddr;
        w_rdFetchLegal = w_arLegal;
      end
      R_DATA:  w_rdFetchAddr = nextAddr(r_rdAddr, r_rdBurst);
      default: w_rdFetchAddr = r_rdAddr;
    endcase
    w_rdFetchErr  = !w_rdFetchLegal || !inRange(w_rdFetchAddr);
    w_rdFetchData = r_mem[wordIdx(w_rdFetchAddr)];
  end

  // Read channel FSM. arready is held low in reset and comes up on the first
  // edge after release, and again on the edge that retires the rlast beat.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rdState <= R_IDLE;
      r_arready <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdAddr  <= '0;
      r_rdRem   <= '0;
      r_rdBurst <= BURST_FIXED;
      r_rdLegal <= 1'b0;
      r_rdCnt   <= '0;
    end else begin
      case (r_rdState)
        R_IDLE: begin
          if (w_arHs) begin
            r_arready <= 1'b0;
            r_rid     <= i_arid;
            r_rdAddr  <= i_araddr;
            r_rdRem   <= i_arlen;
            r_rdBurst <= i_arburst;
            r_rdLegal <= w_arLegal;
            if (READ_LAT == 0) begin
              r_rdState <= R_DATA;
              r_rvalid  <= 1'b1;
              r_rdata   <= w_rdFetchErr ? 32'd0 : w_rdFetchData;
              r_rresp   <= w_rdFetchErr ? RESP_SLVERR : RESP_OKAY;
              r_rlast   <= (i_arlen == 8'd0);
            end else begin
              r_rdState <= R_WAIT;
              r_rdCnt   <= 4'(READ_LAT);
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_rdCnt <= 4'd1) begin
            r_rdState <= R_DATA;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rdFetchErr ? 32'd0 : w_rdFetchData;
            r_rresp   <= w_rdFetchErr ? RESP_SLVERR : RESP_OKAY;
            r_rlast   <= (r_rdRem == 8'd0);
          end else begin
            r_rdCnt <= r_rdCnt - 4'd1;
          end
        end
        R_DATA: begin
          if (w_rHs) begin
            if (r_rlast) begin
              r_rdState <= R_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_rdAddr <= w_rdFetchAddr;
              r_rdRem  <= r_rdRem - 8'd1;
              r_rdata  <= w_rdFetchErr ? 32'd0 : w_rdFetchData;
              r_rresp  <= w_rdFetchErr ? RESP_SLVERR : RESP_OKAY;
              r_rlast  <= (r_rdRem == 8'd1);
            end
          end
        end
        default: r_rdState <= R_IDLE;
      endcase
    end
  end

  assign o_arready = r_arready;
  assign o_rid     = r_rid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_rlast   = r_rlast;
  assign o_rvalid  = r_rvalid;

  // ----------------------------------------------------------------- write
  wrState_t    r_wrState;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp;
  logic [31:0] r_wrAddr;
  logic [7:0]  r_wrRem;
  logic [1:0]  r_wrBurst;
  logic        r_wrLegal;
  logic        r_wrErr;
  logic        r_wrOver;

  logic w_awHs;
  logic w_wHs;
  logic w_bHs;
  logic w_awLegal;
  logic w_wrBeatBad;
  logic w_wrFinal;
  logic w_wrErrNext;
  logic w_wrEn;

  assign w_awHs    = i_awvalid && r_awready;
  assign w_wHs     = i_wvalid && r_wready;
  assign w_bHs     = r_bvalid && i_bready;
  assign w_awLegal = (i_awsize == 3'b010) && (i_awburst == BURST_INCR || i_awburst == BURST_FIXED);

  // r_wrOver marks beats beyond awlen+1 when wlast never came on time: they
  // are swallowed without touching the RAM. A wlast that disagrees with the
  // beat count (early or missing) is a protocol error.
  assign w_wrBeatBad = !r_wrLegal || !inRange(r_wrAddr);
  assign w_wrFinal   = (r_wrRem == 8'd0);
  assign w_wrErrNext = r_wrErr || (!r_wrOver && (w_wrBeatBad || (i_wlast != w_wrFinal)));
  assign w_wrEn      = w_wHs && !r_wrOver && !w_wrBeatBad;

  // Write channel FSM: one AW, its data beats, then a held B response.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wrState <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_wrAddr  <= '0;
      r_wrRem   <= '0;
      r_wrBurst <= BURST_FIXED;
      r_wrLegal <= 1'b0;
      r_wrErr   <= 1'b0;
      r_wrOver  <= 1'b0;
    end else begin
      case (r_wrState)
        W_IDLE: begin
          if (w_awHs) begin
            r_wrState <= W_DATA;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= i_awid;
            r_wrAddr  <= i_awaddr;
            r_wrRem   <= i_awlen;
            r_wrBurst <= i_awburst;
            r_wrLegal <= w_awLegal;
            r_wrErr   <= 1'b0;
            r_wrOver  <= 1'b0;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wHs) begin
            r_wrErr <= w_wrErrNext;
            if (!r_wrOver) begin
              r_wrAddr <= nextAddr(r_wrAddr, r_wrBurst);
              if (!w_wrFinal) r_wrRem <= r_wrRem - 8'd1;
              if (w_wrFinal && !i_wlast) r_wrOver <= 1'b1;
            end
            if (i_wlast) begin
              r_wrState <= W_RESP;
              r_wready  <= 1'b0;
              r_bvalid  <= 1'b1;
              r_bresp   <= w_wrErrNext ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        W_RESP: begin
          if (w_bHs) begin
            r_wrState <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
          end
        end
        default: r_wrState <= W_IDLE;
      endcase
    end
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wstrb[i]) r_mem[wordIdx(r_wrAddr)][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bid     = r_bid;
  assign o_bresp   = r_bresp;
  assign o_bvalid  = r_bvalid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Directed bench for axi_sram_slave. Stimulus tasks push the expected R
//   beats and B responses into queues; monitor processes pop and compare
//   whenever the DUT completes a handshake, and check that stalled payloads
//   hold still.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam int ADDR_BITS = 12;
  localparam int READ_LAT  = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  arId;
  logic [31:0] arAddr;
  logic [7:0]  arLen;
  logic [2:0]  arSize;
  logic [1:0]  arBurst;
  logic        arValid;
  logic        arReady;
  logic [3:0]  rId;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rLast;
  logic        rValid;
  logic        rReady;
  logic [3:0]  awId;
  logic [31:0] awAddr;
  logic [7:0]  awLen;
  logic [2:0]  awSize;
  logic [1:0]  awBurst;
  logic        awValid;
  logic        awReady;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic        wLast;
  logic        wValid;
  logic        wReady;
  logic [3:0]  bId;
  logic [1:0]  bResp;
  logic        bValid;
  logic        bReady;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rBeat_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bResp_t;

  rBeat_t rExpQ[$];
  bResp_t bExpQ[$];
  int     checks    = 0;
  int     failures  = 0;
  int     rPopCnt   = 0;
  bit     rToggle   = 1'b0;
  int     bHoldCnt  = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_BITS(ADDR_BITS), .READ_LAT(READ_LAT)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_arid(arId), .i_araddr(arAddr), .i_arlen(arLen), .i_arsize(arSize), .i_arburst(arBurst),
    .i_arlock(2'b00), .i_arcache(4'b0000), .i_arprot(3'b000),
    .i_arvalid(arValid), .o_arready(arReady),
    .o_rid(rId), .o_rdata(rData), .o_rresp(rResp), .o_rlast(rLast), .o_rvalid(rValid), .i_rready(rReady),
    .i_awid(awId), .i_awaddr(awAddr), .i_awlen(awLen), .i_awsize(awSize), .i_awburst(awBurst),
    .i_awlock(2'b00), .i_awcache(4'b0000), .i_awprot(3'b000),
    .i_awvalid(awValid), .o_awready(awReady),
    .i_wid(4'd0), .i_wdata(wData), .i_wstrb(wStrb), .i_wlast(wLast), .i_wvalid(wValid), .o_wready(wReady),
    .o_bid(bId), .o_bresp(bResp), .o_bvalid(bValid), .i_bready(bReady)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Ready drivers: rready is either held high or toggled every cycle; bready
  // is held low for bHoldCnt cycles of a pending response.
  always @(posedge clk) begin
    #1;
    rReady = rToggle ? ~rReady : 1'b1;
    if (bHoldCnt > 0 && bValid) bHoldCnt--;
    bReady = (bHoldCnt == 0);
  end

  // R monitor: compare each accepted beat against the queue head and check
  // that a stalled beat is still presented unchanged one cycle later.
  rBeat_t rPop;
  rBeat_t rHeld;
  bit     rStall = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      rStall = 1'b0;
    end else begin
      if (rStall) begin
        checkOutput("r_stall_valid", 32'(rValid), 32'd1);
        checkOutput("r_stall_data", rData, rHeld.data);
        checkOutput("r_stall_ctrl", 32'({rId, rResp, rLast}), 32'({rHeld.id, rHeld.resp, rHeld.last}));
      end
      rStall = 1'b0;
      if (rValid) begin
        if (rReady) begin
          if (rExpQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL r_unexpected actual=0x%08h required=no beat", rData);
          end else begin
            rPop = rExpQ.pop_front();
            checkOutput("r_data", rData, rPop.data);
            checkOutput("r_ctrl", 32'({rId, rResp, rLast}), 32'({rPop.id, rPop.resp, rPop.last}));
            rPopCnt++;
          end
        end else begin
          rStall     = 1'b1;
          rHeld.id   = rId;
          rHeld.data = rData;
          rHeld.resp = rResp;
          rHeld.last = rLast;
        end
      end
    end
  end

  // B monitor: same scheme for the write response channel.
  bResp_t bPop;
  bResp_t bHeld;
  bit     bStall = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      bStall = 1'b0;
    end else begin
      if (bStall) begin
        checkOutput("b_stall_valid", 32'(bValid), 32'd1);
        checkOutput("b_stall_ctrl", 32'({bId, bResp}), 32'({bHeld.id, bHeld.resp}));
      end
      bStall = 1'b0;
      if (bValid) begin
        if (bReady) begin
          if (bExpQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL b_unexpected actual=0x%01h required=no response", bResp);
          end else begin
            bPop = bExpQ.pop_front();
            checkOutput("b_resp", 32'({bId, bResp}), 32'({bPop.id, bPop.resp}));
          end
        end else begin
          bStall     = 1'b1;
          bHeld.id   = bId;
          bHeld.resp = bResp;
        end
      end
    end
  end

  task automatic pushR(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp, input logic last);
    rBeat_t b;
    b.id   = id;
    b.data = data;
    b.resp = resp;
    b.last = last;
    rExpQ.push_back(b);
  endtask

  task automatic sendAR(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input bit measure);
    int n;
    arId    = id;
    arAddr  = addr;
    arLen   = len;
    arSize  = size;
    arBurst = burst;
    arValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ar_handshake", 32'(arReady), 32'd1);
    @(posedge clk);
    #1;
    arValid = 1'b0;
    if (measure) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rValid && n < 50);
      checkOutput("r_first_latency", 32'(n), 32'(READ_LAT + 1));
    end
  endtask

  task automatic sendWrite(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                           input int nBeats, input int lastIdx, input logic [1:0] expResp);
    bResp_t e;
    int n;
    e.id   = id;
    e.resp = expResp;
    bExpQ.push_back(e);
    awId    = id;
    awAddr  = addr;
    awLen   = len;
    awSize  = 3'b010;
    awBurst = burst;
    awValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("aw_handshake", 32'(awReady), 32'd1);
    @(posedge clk);
    #1;
    awValid = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      wData  = base + 32'(i);
      wStrb  = strb;
      wLast  = (i == lastIdx);
      wValid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wReady && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!wReady) begin
        checks++;
        failures++;
        $display("[TB] FAIL w_handshake actual=0 required=1 beat=%0d", i);
      end
      @(posedge clk);
      #1;
    end
    wValid = 1'b0;
    wLast  = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((rExpQ.size() != 0 || bExpQ.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("queues_drained", 32'(rExpQ.size() + bExpQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    int n;
    int base;

    // Reset state: everything low, ready comes up only after release.
    #3;
    checkOutput("reset_arready", 32'(arReady), 32'd0);
    checkOutput("reset_awready", 32'(awReady), 32'd0);
    checkOutput("reset_valids", 32'({rValid, wReady, bValid}), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_readies", 32'({arReady, awReady}), 32'b11);
    @(posedge clk);
    #1;

    // 16-beat INCR write then read back, with first-beat latency.
    sendWrite(4'h3, 32'h40, 8'd15, 2'b01, 32'h1000, 4'hF, 16, 15, 2'b00);
    waitDrain();
    for (int i = 0; i < 16; i++) pushR(4'h5, 32'h1000 + 32'(i), 2'b00, i == 15);
    sendAR(4'h5, 32'h40, 8'd15, 3'b010, 2'b01, 1'b1);
    waitDrain();

    // Byte strobes: bits 0 and 2 take bytes DD and BB of the new word.
    sendWrite(4'h1, 32'h8, 8'd0, 2'b01, 32'h11223344, 4'hF, 1, 0, 2'b00);
    sendWrite(4'h2, 32'h8, 8'd0, 2'b01, 32'hAABBCCDD, 4'b0101, 1, 0, 2'b00);
    waitDrain();
    pushR(4'h6, 32'h11BB33DD, 2'b00, 1'b1);
    sendAR(4'h6, 32'h8, 8'd0, 3'b010, 2'b01, 1'b0);
    waitDrain();

    // Backpressure on R (toggling rready) and B (bready low for 5 cycles).
    rToggle = 1'b1;
    for (int i = 0; i < 16; i++) pushR(4'h7, 32'h1000 + 32'(i), 2'b00, i == 15);
    sendAR(4'h7, 32'h40, 8'd15, 3'b010, 2'b01, 1'b0);
    waitDrain();
    rToggle  = 1'b0;
    bHoldCnt = 5;
    sendWrite(4'h9, 32'h100, 8'd3, 2'b01, 32'h2000, 4'hF, 4, 3, 2'b00);
    waitDrain();
    for (int i = 0; i < 4; i++) pushR(4'h9, 32'h2000 + 32'(i), 2'b00, i == 3);
    sendAR(4'h9, 32'h100, 8'd3, 3'b010, 2'b01, 1'b0);
    waitDrain();

    // Illegal arsize: both beats SLVERR with zero data.
    pushR(4'h4, 32'h0, 2'b10, 1'b0);
    pushR(4'h4, 32'h0, 2'b10, 1'b1);
    sendAR(4'h4, 32'h40, 8'd1, 3'b001, 2'b01, 1'b0);
    waitDrain();

    // Out-of-range AW (would alias word 0) must leave word 0 alone.
    sendWrite(4'h1, 32'h0, 8'd0, 2'b01, 32'hCAFEF00D, 4'hF, 1, 0, 2'b00);
    sendWrite(4'h2, 32'h4000, 8'd0, 2'b01, 32'hDEADBEEF, 4'hF, 1, 0, 2'b10);
    waitDrain();
    pushR(4'h2, 32'hCAFEF00D, 2'b00, 1'b1);
    sendAR(4'h2, 32'h0, 8'd0, 3'b010, 2'b01, 1'b0);
    waitDrain();

    // INCR burst running off the top of memory.
    sendWrite(4'h8, 32'h3FFC, 8'd0, 2'b01, 32'h5A5A5A5A, 4'hF, 1, 0, 2'b00);
    waitDrain();
    pushR(4'h8, 32'h5A5A5A5A, 2'b00, 1'b0);
    pushR(4'h8, 32'h0, 2'b10, 1'b0);
    pushR(4'h8, 32'h0, 2'b10, 1'b0);
    pushR(4'h8, 32'h0, 2'b10, 1'b1);
    sendAR(4'h8, 32'h3FFC, 8'd3, 3'b010, 2'b01, 1'b0);
    waitDrain();

    // Early wlast on beat 2 of a 4-beat burst, then a clean single write.
    sendWrite(4'hA, 32'h200, 8'd3, 2'b01, 32'h300, 4'hF, 2, 1, 2'b10);
    sendWrite(4'hB, 32'h300, 8'd0, 2'b01, 32'h33, 4'hF, 1, 0, 2'b00);
    waitDrain();

    // Missing wlast: third beat is discarded, word 0x508 keeps its value.
    sendWrite(4'hC, 32'h508, 8'd0, 2'b01, 32'h0BADC0DE, 4'hF, 1, 0, 2'b00);
    sendWrite(4'hD, 32'h500, 8'd1, 2'b01, 32'h77, 4'hF, 3, 2, 2'b10);
    waitDrain();
    pushR(4'hD, 32'h77, 2'b00, 1'b0);
    pushR(4'hD, 32'h78, 2'b00, 1'b0);
    pushR(4'hD, 32'h0BADC0DE, 2'b00, 1'b1);
    sendAR(4'hD, 32'h500, 8'd2, 3'b010, 2'b01, 1'b0);
    waitDrain();

    // FIXED bursts stay on one word: last write wins, reads repeat it.
    sendWrite(4'hE, 32'h600, 8'd2, 2'b00, 32'h61, 4'hF, 3, 2, 2'b00);
    waitDrain();
    pushR(4'hE, 32'h63, 2'b00, 1'b0);
    pushR(4'hE, 32'h63, 2'b00, 1'b1);
    sendAR(4'hE, 32'h600, 8'd1, 3'b010, 2'b00, 1'b0);
    waitDrain();

    // Reset in the middle of a 16-beat read.
    for (int i = 0; i < 16; i++) pushR(4'hC, 32'h1000 + 32'(i), 2'b00, i == 15);
    base = rPopCnt;
    sendAR(4'hC, 32'h40, 8'd15, 3'b010, 2'b01, 1'b0);
    n = 0;
    while (rPopCnt < base + 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("midreset_rvalid", 32'({rValid, rLast}), 32'd0);
    checkOutput("midreset_arready", 32'(arReady), 32'd0);
    rExpQ.delete();
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("postreset_arready", 32'(arReady), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) pushR(4'h5, 32'h1000 + 32'(i), 2'b00, i == 15);
    sendAR(4'h5, 32'h40, 8'd15, 3'b010, 2'b01, 1'b0);
    waitDrain();
  endtask

  initial begin
    resetn  = 1'b0;
    arId    = '0;
    arAddr  = '0;
    arLen   = '0;
    arSize  = '0;
    arBurst = '0;
    arValid = 1'b0;
    rReady  = 1'b1;
    awId    = '0;
    awAddr  = '0;
    awLen   = '0;
    awSize  = '0;
    awBurst = '0;
    awValid = 1'b0;
    wData   = '0;
    wStrb   = '0;
    wLast   = 1'b0;
    wValid  = 1'b0;
    bReady  = 1'b1;
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
